// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter for the register-file write port, with a registered write stage and a contention counter.
// Optional macro RF_WB_BYPASS_EN forwards the in-flight write onto the read data outputs.
module regfile_wb_arbiter #(
  parameter int NREQ = 2,
  parameter int AW   = 5,
  parameter int DW   = 32,
  parameter int CW   = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 stall,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*AW-1:0]   req_rd,
  input  logic [NREQ*DW-1:0]   req_data,
  output logic [NREQ-1:0]      req_ready,
  output logic [AW-1:0]        RD,
  output logic [DW-1:0]        WriteData,
  output logic                 RegWrite,
  input  logic [AW-1:0]        Read1,
  input  logic [AW-1:0]        Read2,
  input  logic [DW-1:0]        rf_data1,
  input  logic [DW-1:0]        rf_data2,
  output logic [DW-1:0]        fwd_data1,
  output logic [DW-1:0]        fwd_data2,
  output logic [CW-1:0]        contention_cnt
);

  localparam int PW = (NREQ > 2) ? 2 : 1;

  logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
  logic            reg_write_q, reg_write_d;
  logic [AW-1:0]   rd_q, rd_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic [NREQ-1:0] gnt;
  logic [PW-1:0]   gnt_idx;
  logic            handshake;
  logic [AW-1:0]   sel_rd;
  logic [DW-1:0]   sel_data;
  logic            contended;

  // Scan from rr_ptr upward, wrapping, and take the first valid requester.
  always_comb begin : grant_scan
    int idx;
    // NOTE: every output of a combinational block gets a default up front so no path leaves it unassigned (no latch).
    gnt     = '0;
    gnt_idx = '0;
    idx     = 0;
    if (!stall) begin
      for (int k = NREQ - 1; k >= 0; k--) begin
        idx = (int'(rr_ptr_q) + k) % NREQ;
        if (req_valid[idx]) begin
          gnt     = '0;
          gnt[idx] = 1'b1;
          gnt_idx = PW'(idx);
        end
      end
    end
  end

  assign req_ready = reset ? '0 : gnt;
  assign handshake = |(req_valid & req_ready);
  assign sel_rd    = req_rd[int'(gnt_idx)*AW +: AW];
  assign sel_data  = req_data[int'(gnt_idx)*DW +: DW];
  assign contended = ($countones(req_valid) >= 2);

  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    rd_d        = rd_q;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;
    reg_write_d = handshake && (sel_rd != '0);
    if (handshake) rr_ptr_d = PW'((int'(gnt_idx) + 1) % NREQ);
    // Writes to x0 are accepted but leave the address/data registers untouched.
    if (reg_write_d) begin
      rd_d    = sel_rd;
      wdata_d = sel_data;
    end
    if (contended && (cnt_q != '1)) cnt_d = cnt_q + CW'(1);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rr_ptr_q    <= '0;
      reg_write_q <= 1'b0;
      rd_q        <= '0;
      wdata_q     <= '0;
      cnt_q       <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      reg_write_q <= reg_write_d;
      rd_q        <= rd_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
    end
  end

  assign RegWrite       = reg_write_q;
  assign RD             = rd_q;
  assign WriteData      = wdata_q;
  assign contention_cnt = cnt_q;

`ifdef RF_WB_BYPASS_EN
  assign fwd_data1 = (reg_write_q && (rd_q != '0) && (rd_q == Read1)) ? wdata_q : rf_data1;
  assign fwd_data2 = (reg_write_q && (rd_q != '0) && (rd_q == Read2)) ? wdata_q : rf_data2;
`else
  logic unused_read;
  assign unused_read = ^{Read1, Read2};
  assign fwd_data1   = rf_data1;
  assign fwd_data2   = rf_data2;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: grant order, write stage, x0 drop, stall, reset, bypass, saturation.
module tb_regfile_wb_arbiter;

  localparam int NREQ = 2;
  localparam int AW   = 5;
  localparam int DW   = 32;
  localparam int CW   = 4;

  logic                 clock = 1'b0;
  logic                 reset;
  logic                 stall;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ*AW-1:0]   req_rd;
  logic [NREQ*DW-1:0]   req_data;
  logic [NREQ-1:0]      req_ready;
  logic [AW-1:0]        RD;
  logic [DW-1:0]        WriteData;
  logic                 RegWrite;
  logic [AW-1:0]        Read1, Read2;
  logic [DW-1:0]        rf_data1, rf_data2;
  logic [DW-1:0]        fwd_data1, fwd_data2;
  logic [CW-1:0]        contention_cnt;

  int checks = 0;
  int errors = 0;

  regfile_wb_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .CW(CW)) dut (
    .clock(clock), .reset(reset), .stall(stall),
    .req_valid(req_valid), .req_rd(req_rd), .req_data(req_data), .req_ready(req_ready),
    .RD(RD), .WriteData(WriteData), .RegWrite(RegWrite),
    .Read1(Read1), .Read2(Read2), .rf_data1(rf_data1), .rf_data2(rf_data2),
    .fwd_data1(fwd_data1), .fwd_data2(fwd_data2), .contention_cnt(contention_cnt)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [1:0] v, input logic [AW-1:0] rd0, input logic [DW-1:0] d0,
                       input logic [AW-1:0] rd1, input logic [DW-1:0] d1);
    req_valid = v;
    req_rd    = {rd1, rd0};
    req_data  = {d1, d0};
  endtask

  task automatic edge_then_sample();
    @(posedge clock);
    #1;
  endtask

  logic [1:0] exp_gnt [4];
  logic [4:0] exp_rd  [4];

  initial begin
    exp_gnt = '{2'b10, 2'b01, 2'b10, 2'b01};
    exp_rd  = '{5'd5, 5'd3, 5'd5, 5'd3};
    reset = 1'b1; stall = 1'b0;
    Read1 = '0; Read2 = '0; rf_data1 = '0; rf_data2 = '0;
    drive(2'b11, 5'd3, 32'h1, 5'd4, 32'h2);

    // Reset state, ready held low during reset even with requests pending
    edge_then_sample();
    check("rst_ready", req_ready, 2'b00);
    check("rst_regwrite", RegWrite, 1'b0);
    check("rst_rd", RD, 5'd0);
    check("rst_wdata", WriteData, 32'h0);
    check("rst_cnt", contention_cnt, 4'd0);

    // Test 1: single write from requester 0
    @(negedge clock);
    reset = 1'b0;
    drive(2'b01, 5'd3, 32'hABCDEFFF, 5'd0, 32'h0);
    #1 check("t1_ready", req_ready, 2'b01);
    edge_then_sample();
    check("t1_regwrite", RegWrite, 1'b1);
    check("t1_rd", RD, 5'd3);
    check("t1_wdata", WriteData, 32'hABCDEFFF);
    @(negedge clock);
    drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    edge_then_sample();
    check("t1_pulse_end", RegWrite, 1'b0);
    check("t1_rd_hold", RD, 5'd3);

    // Test 2: both valid; rr_ptr=1 so grants go 10,01,10,01
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      drive(2'b11, 5'd3, 32'h11111111, 5'd5, 32'hFBCDE111);
      #1 check($sformatf("t2_gnt%0d", c), req_ready, exp_gnt[c]);
      edge_then_sample();
      check($sformatf("t2_rd%0d", c), RD, exp_rd[c]);
      check($sformatf("t2_wdata%0d", c), WriteData, (exp_rd[c] == 5'd5) ? 32'hFBCDE111 : 32'h11111111);
      check($sformatf("t2_we%0d", c), RegWrite, 1'b1);
    end
    check("t2_cnt", contention_cnt, 4'd4);

    // Test 3: write to x0 is accepted but dropped
    @(negedge clock);
    drive(2'b01, 5'd0, 32'hDEADBEEF, 5'd0, 32'h0);
    #1 check("t3_ready", req_ready, 2'b01);
    edge_then_sample();
    check("t3_regwrite", RegWrite, 1'b0);
    check("t3_rd_hold", RD, 5'd3);
    check("t3_wdata_hold", WriteData, 32'h11111111);

    // Test 4: stall blocks grants but contention still counts; rr_ptr now 1
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      stall = 1'b1;
      drive(2'b11, 5'd3, 32'h33333333, 5'd5, 32'h55555555);
      #1 check($sformatf("t4_ready%0d", c), req_ready, 2'b00);
      edge_then_sample();
      check($sformatf("t4_we%0d", c), RegWrite, 1'b0);
    end
    check("t4_cnt", contention_cnt, 4'd7);
    @(negedge clock);
    stall = 1'b0;
    #1 check("t4_release_gnt", req_ready, 2'b10);
    edge_then_sample();
    check("t4_rd", RD, 5'd5);
    check("t4_wdata", WriteData, 32'h55555555);
    check("t4_cnt2", contention_cnt, 4'd8);

    // Test 5: reset while a write is in flight cancels it immediately
    @(negedge clock);
    drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    check("t5_pre_we", RegWrite, 1'b1);
    #1 reset = 1'b1;
    #1;
    check("t5_regwrite", RegWrite, 1'b0);
    check("t5_rd", RD, 5'd0);
    check("t5_wdata", WriteData, 32'h0);
    check("t5_cnt", contention_cnt, 4'd0);

    // Test 6: forwarding of the in-flight write onto read port 1
    @(negedge clock);
    reset = 1'b0;
    Read1 = 5'd7; Read2 = 5'd10; rf_data1 = 32'h0; rf_data2 = 32'h5;
    drive(2'b01, 5'd7, 32'h00000042, 5'd0, 32'h0);
    #1 check("t6_ready", req_ready, 2'b01);
    edge_then_sample();
    check("t6_rd", RD, 5'd7);
`ifdef RF_WB_BYPASS_EN
    check("t6_fwd1", fwd_data1, 32'h42);
`else
    check("t6_fwd1", fwd_data1, 32'h0);
`endif
    check("t6_fwd2", fwd_data2, 32'h5);
    @(negedge clock);
    drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    rf_data1 = 32'h9;
    edge_then_sample();
    check("t6_fwd1_idle", fwd_data1, 32'h9);

    // Contention counter saturates at all-ones
    @(negedge clock);
    stall = 1'b1;
    drive(2'b11, 5'd1, 32'h1, 5'd2, 32'h2);
    repeat (20) @(posedge clock);
    #1 check("sat_cnt", contention_cnt, 4'hF);
    check("sat_we", RegWrite, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
